// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter and serial frame sequencer for four requesters.
// Frame: start, 2-bit ID, 4-bit len, data; optional parity via SERTX_PARITY_EN.
module serial_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clkEn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data_i,
    input  logic [NREQ*LEN_W-1:0]  len_i,
    output logic [NREQ-1:0]        gnt,
    output logic                   serOut,
    output logic                   SerOutValid,
    output logic                   busy,
    output logic                   Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ID    = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
`ifdef SERTX_PARITY_EN
        S_PAR   = 3'd5,
`endif
        S_STOP  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_nstate;
    state_t              w_tail;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_ncnt;
    logic [LEN_W-1:0]    w_didx;
    logic [1:0]          r_ptr;
    logic [1:0]          r_id;
    logic [LEN_W-1:0]    r_len;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          w_sel;
    logic [1:0]          w_idx;
    logic                w_hit;
    logic                w_take;
    logic                w_dbit;
    logic                w_par;

    assign w_take = (r_state == S_IDLE) && clkEn && (|req);
    assign w_didx = r_cnt - LEN_W'(1);
    assign w_dbit = r_data[w_didx];
    assign gnt    = (w_take && rst) ? (NREQ'(1) << w_sel) : '0;

`ifdef SERTX_PARITY_EN
    logic r_par;
    assign w_tail = S_PAR;
    assign w_par  = r_par;

    // running XOR of the data bits actually sent
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_take) begin
            r_par <= 1'b0;
        end else if (clkEn && r_state == S_DATA) begin
            r_par <= r_par ^ w_dbit;
        end
    end
`else
    assign w_tail = S_STOP;
    assign w_par  = 1'b0;
`endif

    // first asserted requester after the last winner
    always_comb begin
        w_sel = r_ptr;
        w_hit = 1'b0;
        w_idx = r_ptr;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_hit && req[w_idx]) begin
                w_sel = w_idx;
                w_hit = 1'b1;
            end
        end
    end

    // state, counter and frame payload registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= 2'd3;
            r_id    <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if (w_take) begin
                r_ptr  <= w_sel;
                r_id   <= w_sel;
                r_len  <= len_i[w_sel*LEN_W +: LEN_W];
                r_data <= data_i[w_sel*DATA_W +: DATA_W];
            end
        end
    end

    // next state and Moore line outputs
    always_comb begin
        w_nstate    = r_state;
        w_ncnt      = r_cnt;
        serOut      = 1'b1;
        SerOutValid = 1'b0;
        busy        = 1'b1;
        Done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                Done = 1'b1;
                if (w_take) w_nstate = S_START;
            end
            S_START: begin
                serOut = 1'b0;
                if (clkEn) begin
                    w_nstate = S_ID;
                    w_ncnt   = LEN_W'(1);
                end
            end
            S_ID: begin
                serOut = r_id[r_cnt[0]];
                if (clkEn) begin
                    if (r_cnt == '0) begin
                        w_nstate = S_LEN;
                        w_ncnt   = LEN_W'(LEN_W - 1);
                    end else begin
                        w_ncnt = r_cnt - LEN_W'(1);
                    end
                end
            end
            S_LEN: begin
                serOut = r_len[r_cnt[1:0]];
                if (clkEn) begin
                    if (r_cnt != '0) begin
                        w_ncnt = r_cnt - LEN_W'(1);
                    end else if (r_len == '0) begin
                        w_nstate = w_tail;
                    end else begin
                        w_nstate = S_DATA;
                        w_ncnt   = r_len;
                    end
                end
            end
            S_DATA: begin
                serOut      = w_dbit;
                SerOutValid = 1'b1;
                if (clkEn) begin
                    w_ncnt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) w_nstate = w_tail;
                end
            end
`ifdef SERTX_PARITY_EN
            S_PAR: begin
                serOut = w_par;
                if (clkEn) w_nstate = S_STOP;
            end
`endif
            S_STOP: begin
                serOut = 1'b1;
                if (clkEn) w_nstate = S_IDLE;
            end
            default: begin
                w_nstate = S_IDLE;
                serOut   = w_par | 1'b1;
            end
        endcase
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Round-robin arbiter and frame sequencer that shares one serial output line among four requesters. Each granted requester's payload goes out as one serial frame: start bit, 2-bit requester ID, 4-bit length, then data bits. This frame format is the one the team's serial receiver/demux controller consumes. The block sits on the transmit side of the serial link, and all bit timing is paced by the same `clkEn` strobe as the receiver.

## Interface
- `NREQ`, 4: number of requesters. Fixed at 4 because the ID field is 2 bits.
- `DATA_W`, 16: width of each requester's data word.
- `LEN_W`, 4: width of the length field. Maximum data bits per frame is 15.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `clkEn` input 1: bit-rate strobe; state advances only on cycles where it is high.
- `req` input 4: per-requester request level; held until granted.
- `data_i` input 4*DATA_W: packed data words; requester k uses `[k*DATA_W +: DATA_W]`.
- `len_i` input 4*LEN_W: packed data-bit counts (0..15) per requester.
- `gnt` output 4: one-hot, one-cycle grant pulse; payload is captured on that edge.
- `serOut` output 1: serial line; idles high.
- `SerOutValid` output 1: high while data bits are on `serOut`.
- `busy` output 1: high from START through STOP.
- `Done` output 1: high in IDLE.

## Operation
- States: IDLE, START, ID, LEN, DATA, (PAR), STOP.
- All transitions require `clkEn`=1; with `clkEn`=0 the state, counters and shift registers hold.
- **IDLE**
  - `serOut`=1, `Done`=1.
  - If `clkEn` and `|req`: grant the first asserted requester searching from `ptr+1` mod 4 upward.
  - On a grant: pulse `gnt[k]`, latch `data_i[k]`, `len_i[k]` and ID k; set `ptr`=k; go to START.
- **START**: `serOut`=0 for one bit, then go to ID.
- **ID**: 2 bits, MSB first, via a bit counter; then go to LEN.
- **LEN**: 4 bits, MSB first.
  - If latched len=0, go directly to STOP (or to PAR when enabled).
  - Otherwise go to DATA with the data counter loaded to len.
- **DATA**
  - Sends `data[len-1:0]` MSB first; `SerOutValid`=1; counter decrements each bit.
  - When the counter reaches 1 and `clkEn`=1, go to STOP (or PAR).
- **STOP**: `serOut`=1 for one bit, then go to IDLE.
- No grant is issued in STOP. The earliest next grant is the first `clkEn` cycle in IDLE, so frames are separated by at least one idle-high bit.
- Data bits above len are ignored. `req` changes after a grant do not affect the frame in flight.
- `gnt` is Mealy: IDLE & `clkEn` & `|req`. All other outputs are Moore, decoded from registered state and shift registers, with no combinational path from inputs.

## Timing
- Reset (`rst`=0, any time including mid-frame) immediately forces:
  - state IDLE, `ptr`=3 (requester 0 has first priority);
  - `serOut`=1, `Done`=1;
  - `gnt`=0, `SerOutValid`=0, `busy`=0;
  - counters and shift registers 0.
- A frame in progress at reset is abandoned, not resumed.
- Frame length is 8+len enabled bits, or 9+len when PAR is enabled. Each bit lasts exactly one `clkEn` period.
- Grant latency:
  - `req` sampled high on a `clkEn` cycle in IDLE produces `gnt` in that same cycle.
  - START appears on `serOut` after the next clock edge.
- Simultaneous requests resolve in round-robin order. A requester holding `req` high is guaranteed a grant within 4 frames.

## Configuration
- `SERTX_PARITY_EN` defined:
  - PAR state is inserted after DATA, or after LEN when len=0.
  - PAR sends the even parity of the transmitted data bits (XOR of `data[len-1:0]`, 0 when len=0).
  - `SerOutValid` is low during PAR.
- `SERTX_PARITY_EN` undefined: PAR state and parity logic are absent, and LEN/DATA go straight to STOP.

## Test plan
- **Single frame**
  - Stimulus: `req`=0001, `data_i[0]`=16'h00A5, `len_i[0]`=8, `clkEn`=1.
  - Response: one `gnt`=0001 pulse; `serOut` = 0,0,0,1,0,0,0,1,0,1,0,0,1,0,1,1.
  - `SerOutValid` high for exactly the 8 data bits.
- **Round-robin**
  - Stimulus: `req`=1111 held, all len=1.
  - Response: grants in order 0001, 0010, 0100, 1000, 0001; each frame 9 bits; at least one idle-high bit between frames.
- **Zero length**
  - Stimulus: `req`=0100, `len_i[2]`=0.
  - Response: `serOut` = 0,1,0,0,0,0,0,1; `SerOutValid` never high.
- **clkEn pacing**
  - Stimulus: `clkEn` high every 4th cycle, single 8+len frame.
  - Response: every `serOut` bit held exactly 4 clocks; `gnt` pulse aligned to a `clkEn` cycle.
- **Reset mid-frame**
  - Stimulus: pull `rst` low during DATA.
  - Response: same cycle `serOut`=1, `busy`=0, `Done`=1.
  - After release with `req`=1111: first grant is 0001.
- **Parity** (`SERTX_PARITY_EN`)
  - Stimulus: frame with data 8'hA5, len=8 → PAR bit 0, frame length 17 bits.
  - Stimulus: data 8'hA4, len=8 → PAR bit 1.
